// File: rtl/uart_pkg.sv
// uart_pkg: shared state/parity encodings and the 3-sample bit voter for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick generator, restartable so ticks align to the start edge
module uart_baud_tick #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  if (TICK_DIV < 1) begin : g_div_chk
    $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE");
  end
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  // divider restarts on clear so the first tick lands TICK_DIV cycles after the start edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver with parity/framing/overrun errors and ready/valid output
module uart_rx_os #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int IDLE_CYCLES = 20_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 data_end,
  output logic                 busy
);
  import uart_pkg::*;
  localparam int HALF = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  rx_state_t state, nxt;
  logic rx_m, rx_s, tick, s_a, s_b, fbad, par_ok, armed;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] icnt;
  logic [DATA_BITS-1:0] shreg;
  logic start_det, vtick, etick, vote, last_data, last_stop, complete, fbad_now, deliver;
  logic idle_cnt_en, data_end_hit;
  assign start_det = state == IDLE && !rx_s;
  assign vtick = tick && tcnt == TW'(HALF + 1);
  assign etick = tick && tcnt == TW'(OVERSAMPLE - 1);
  assign vote = majority(s_a, s_b, rx_s);
  assign last_data = bcnt == BW'(DATA_BITS - 1);
  assign last_stop = bcnt == BW'(STOP_BITS - 1);
  assign complete = state == STOP && vtick && last_stop;
  assign fbad_now = fbad || !vote;
  assign deliver = complete && !fbad_now && par_ok;
  assign idle_cnt_en = state == IDLE && rx_s && icnt != IW'(IDLE_CYCLES);
  assign data_end_hit = idle_cnt_en && armed && icnt == IW'(IDLE_CYCLES - 1);
  assign busy = state != IDLE;
  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst_n(rst_n), .clear(start_det), .tick(tick)
  );
  // two-flop synchroniser; the line idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, rx};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: frames end at the mid-bit vote of the last stop bit
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:             if (!rx_s) nxt = START;
      START:            nxt = (vtick && vote) ? IDLE : (etick ? DATA : START);
      DATA:             if (etick && last_data) nxt = PARITY != 0 ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (etick) nxt = STOP;
      STOP:             if (complete) nxt = fbad_now ? WAIT_HIGH : IDLE;
      WAIT_HIGH:        if (rx_s) nxt = IDLE;
      default:          nxt = IDLE;
    endcase
  end
  // bit timing, vote samples, payload shift and per-frame error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      bcnt <= '0;
      s_a <= 1'b1;
      s_b <= 1'b1;
      shreg <= '0;
      fbad <= 1'b0;
      par_ok <= 1'b1;
    end else if (start_det) begin
      tcnt <= '0;
      bcnt <= '0;
      fbad <= 1'b0;
      par_ok <= 1'b1;
    end else if (tick) begin
      tcnt <= etick ? '0 : tcnt + 1'b1;
      if (tcnt == TW'(HALF - 1)) s_a <= rx_s;
      if (tcnt == TW'(HALF)) s_b <= rx_s;
      if (vtick && state == DATA) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (vtick && state == uart_pkg::PARITY) par_ok <= ((^shreg) ^ vote) == (PARITY == int'(PAR_ODD));
      if (vtick && state == STOP) fbad <= fbad_now;
      if (etick && (state == DATA || state == STOP)) bcnt <= (state == DATA && last_data) ? '0 : bcnt + 1'b1;
    end
  // output buffer, error pulses and end-of-burst detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      valid_out <= 1'b0;
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      data_end <= 1'b0;
      armed <= 1'b0;
      icnt <= '0;
    end else begin
      parity_err <= complete && !fbad_now && !par_ok;
      framing_err <= complete && fbad_now;
      overrun_err <= deliver && valid_out && !ready_in;
      data_end <= data_end_hit;
      if (deliver && (!valid_out || ready_in)) begin
        data <= shreg;
        valid_out <= 1'b1;
      end else if (ready_in) valid_out <= 1'b0;
      armed <= complete ? 1'b1 : (data_end_hit ? 1'b0 : armed);
      icnt <= start_det ? '0 : (idle_cnt_en ? icnt + 1'b1 : icnt);
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os (8N1 instance and 8E1 instance, 32 clk per bit)
module tb_uart_rx_os;
  logic clk = 0, rst_n = 0, rx = 1, rx_p = 1, ready = 1, ready_p = 1;
  logic [7:0] data, data_p;
  logic valid, valid_p, pe, pe_p, fe, fe_p, oe, oe_p, de, de_p, busy, busy_p;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  int v_rises = 0, vp_rises = 0, pe_n = 0, pep_n = 0, fe_n = 0, oe_n = 0, de_n = 0, busy_n = 0;
  int v_cyc = 0, de_cyc = 0;
  logic v_q = 0, vp_q = 0;

  uart_rx_os #(.CLK_FREQ(32_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1), .IDLE_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid_out(valid), .ready_in(ready),
    .parity_err(pe), .framing_err(fe), .overrun_err(oe), .data_end(de), .busy(busy));

  uart_rx_os #(.CLK_FREQ(32_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(2), .STOP_BITS(1), .IDLE_CYCLES(100)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .data(data_p), .valid_out(valid_p), .ready_in(ready_p),
    .parity_err(pe_p), .framing_err(fe_p), .overrun_err(oe_p), .data_end(de_p), .busy(busy_p));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event counters sampled on the falling edge
  always @(negedge clk) begin
    if (valid && !v_q) begin v_rises++; v_cyc = cyc; end
    if (valid_p && !vp_q) vp_rises++;
    v_q = valid;
    vp_q = valid_p;
    if (pe) pe_n++;
    if (pe_p) pep_n++;
    if (fe) fe_n++;
    if (oe) oe_n++;
    if (de) begin de_n++; de_cyc = cyc; end
    if (busy) busy_n++;
  end

  task automatic send(input int n, input logic [15:0] v, input bit p);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (p) rx_p = v[i]; else rx = v[i];
      last_cyc = cyc;
      repeat (31) @(negedge clk);
    end
  endtask

  task automatic frame8(input logic [7:0] d);
    send(10, {6'h0, 1'b1, d, 1'b0}, 0);
  endtask

  task automatic frame_par(input logic [7:0] d, input logic p);
    send(11, {5'h0, 1'b1, p, d, 1'b0}, 1);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({pe, fe, oe, de} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {pe, fe, oe, de}); end
    rst_n = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    for (int k = 0; k < 4; k++) begin
      int v0 = v_rises, e0 = pe_n + fe_n + oe_n;
      frame8(pats[k]);
      repeat (4) @(negedge clk);
      checks++; if (v_rises - v0 !== 1) begin errors++; $display("FAIL basic_rise[%0d]: got %0d expected 1", k, v_rises - v0); end
      checks++; if (data !== pats[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", k, data, pats[k]); end
      checks++; if (pe_n + fe_n + oe_n - e0 !== 0) begin errors++; $display("FAIL basic_err[%0d]: got %0d expected 0", k, pe_n + fe_n + oe_n - e0); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall[%0d]: got %b expected 0", k, valid); end
      if (k == 0) begin
        checks++;
        if (v_cyc - last_cyc < 18 || v_cyc - last_cyc > 26) begin
          errors++; $display("FAIL basic_latency: got %0d expected 18..26 clk after stop start", v_cyc - last_cyc);
        end
      end
    end
  endtask

  task automatic test_false_start;
    int b0 = busy_n, v0 = v_rises, e0 = pe_n + fe_n + oe_n;
    @(negedge clk) rx = 0;
    repeat (8) @(negedge clk);
    rx = 1;
    repeat (60) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy: got %b expected 0", busy); end
    checks++; if (busy_n - b0 <= 0) begin errors++; $display("FAIL false_busy_seen: got %0d busy cycles expected >0", busy_n - b0); end
    checks++; if (v_rises - v0 !== 0) begin errors++; $display("FAIL false_valid: got %0d expected 0", v_rises - v0); end
    checks++; if (pe_n + fe_n + oe_n - e0 !== 0) begin errors++; $display("FAIL false_err: got %0d expected 0", pe_n + fe_n + oe_n - e0); end
  endtask

  task automatic test_parity;
    int p0 = pep_n, v0 = vp_rises;
    frame_par(8'h03, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (pep_n - p0 !== 1) begin errors++; $display("FAIL par_bad_err: got %0d expected 1", pep_n - p0); end
    checks++; if (vp_rises - v0 !== 0) begin errors++; $display("FAIL par_bad_valid: got %0d expected 0", vp_rises - v0); end
    frame_par(8'h03, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (vp_rises - v0 !== 1) begin errors++; $display("FAIL par_ok_valid: got %0d expected 1", vp_rises - v0); end
    checks++; if (data_p !== 8'h03) begin errors++; $display("FAIL par_ok_data: got %h expected 03", data_p); end
    frame_par(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (data_p !== 8'h07) begin errors++; $display("FAIL par_odd_data: got %h expected 07", data_p); end
    checks++; if (pep_n - p0 !== 1) begin errors++; $display("FAIL par_total_err: got %0d expected 1", pep_n - p0); end
  endtask

  task automatic test_framing;
    int f0 = fe_n, v0 = v_rises;
    send(9, {7'h0, 8'h3C, 1'b0}, 0);
    @(negedge clk) rx = 0;
    repeat (95) @(negedge clk);
    checks++; if (fe_n - f0 !== 1) begin errors++; $display("FAIL frame_err: got %0d expected 1", fe_n - f0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_low: got %b expected 1", busy); end
    checks++; if (v_rises - v0 !== 0) begin errors++; $display("FAIL frame_valid: got %0d expected 0", v_rises - v0); end
    rx = 1;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_high: got %b expected 0", busy); end
    frame8(8'h5A);
    repeat (4) @(negedge clk);
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL frame_next_data: got %h expected 5a", data); end
    checks++; if (v_rises - v0 !== 1 || fe_n - f0 !== 1) begin errors++; $display("FAIL frame_next_counts: got rises %0d ferr %0d expected 1 1", v_rises - v0, fe_n - f0); end
  endtask

  task automatic test_overrun;
    int o0 = oe_n, v0 = v_rises;
    ready = 0;
    frame8(8'h11);
    frame8(8'h22);
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", data); end
    checks++; if (oe_n - o0 !== 1) begin errors++; $display("FAIL ovr_err: got %0d expected 1", oe_n - o0); end
    checks++; if (v_rises - v0 !== 1) begin errors++; $display("FAIL ovr_rises: got %0d expected 1", v_rises - v0); end
    ready = 1;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", valid); end
  endtask

  task automatic test_data_end;
    int d0, v0;
    repeat (150) @(negedge clk);
    d0 = de_n;
    v0 = v_rises;
    frame8(8'h7E);
    repeat (300) @(negedge clk);
    checks++; if (data !== 8'h7E) begin errors++; $display("FAIL dend_data: got %h expected 7e", data); end
    checks++; if (de_n - d0 !== 1) begin errors++; $display("FAIL dend_count: got %0d expected 1", de_n - d0); end
    checks++; if (de_cyc - v_cyc !== 100) begin errors++; $display("FAIL dend_delay: got %0d expected 100", de_cyc - v_cyc); end
  endtask

  task automatic test_reset_mid;
    ready = 0;
    frame8(8'h3C);
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", valid); end
    send(5, {11'h0, 4'b0001, 1'b0}, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %b expected 1", busy); end
    @(negedge clk) rst_n = 0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    rx = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    ready = 1;
    repeat (5) @(negedge clk);
    frame8(8'h81);
    repeat (4) @(negedge clk);
    checks++; if (data !== 8'h81) begin errors++; $display("FAIL rmid_recover: got %h expected 81", data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_framing();
    test_overrun();
    test_data_end();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
